// File: rtl/spi_burst_sequencer.sv
// Multi-byte SPI burst sequencer: TX/RX byte FIFOs around a byte-wide SPI
// controller, issuing every byte of a burst under a single chip-select window.
module spi_burst_sequencer #(
    parameter int DEPTH    = 8,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    localparam int LW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tx_we,
    input  logic [7:0]    tx_wdata,
    input  logic          rx_re,
    output logic [7:0]    rx_rdata,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          keep_cs,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] tx_count,
    output logic [LW-1:0] rx_count,
    output logic          err,
    input  logic          err_clr,
    output logic          spi_trigger,
    output logic [7:0]    spi_command,
    input  logic          spi_busy,
    input  logic [7:0]    spi_response,
    output logic          spi_cs_n
);
    localparam int AW   = $clog2(DEPTH);
    localparam int TMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [LW-1:0] FULL       = LW'(DEPTH);
    localparam logic [LW-1:0] ONE        = LW'(1);
    localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD - 1);
    localparam logic [TW-1:0] HOLD_END   = TW'(CS_HOLD);

    typedef enum logic [2:0] {
        IDLE, SETUP, ISSUE, WAIT_HI, WAIT_LO, CAPTURE, HOLD, FINISH
    } state_t;

    state_t        state;
    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [LW-1:0] remaining;
    logic          keep_cs_r;
    logic [TW-1:0] timer;

    logic accept, issue_next;
    logic tx_push, tx_pop, tx_drop;
    logic rx_push, rx_pop, rx_drop, capture;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        accept     = 1'b0;
        issue_next = 1'b0;
        case (state)
            IDLE: begin
                accept     = start;
                issue_next = start && (len != '0) && !spi_cs_n;
            end
            SETUP:   issue_next = (timer == SETUP_LAST);
            CAPTURE: issue_next = (remaining != ONE);
            default: ;
        endcase
    end

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign tx_pop   = issue_next && (tx_count != '0);
    assign tx_push  = tx_we && ((tx_count != FULL) || tx_pop);
    assign tx_drop  = tx_we && !tx_push;
    assign capture  = (state == CAPTURE);
    assign rx_pop   = rx_re && (rx_count != '0);
    assign rx_push  = capture && ((rx_count != FULL) || rx_pop);
    assign rx_drop  = capture && !rx_push;
    assign rx_rdata = (rx_count != '0) ? rx_mem[rx_rd_ptr] : 8'h00;

    // NOTE: storage arrays carry no reset; the counts alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= tx_wdata;
        if (rx_push) rx_mem[rx_wr_ptr] <= spi_response;
    end

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            err       <= 1'b0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + ONE;
                2'b01:   tx_count <= tx_count - ONE;
                default: ;
            endcase
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + ONE;
                2'b01:   rx_count <= rx_count - ONE;
                default: ;
            endcase
            if (tx_drop || rx_drop) err <= 1'b1;
            else if (err_clr)       err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            spi_trigger <= 1'b0;
            spi_command <= 8'h00;
            spi_cs_n    <= 1'b1;
            remaining   <= '0;
            keep_cs_r   <= 1'b0;
            timer       <= '0;
        end else begin
            done        <= 1'b0;
            spi_trigger <= 1'b0;
            // Command is loaded with the trigger and then held until the next issue.
            if (issue_next) begin
                spi_trigger <= 1'b1;
                spi_command <= (tx_count != '0) ? tx_mem[tx_rd_ptr] : 8'h00;
            end
            case (state)
                IDLE: if (accept) begin
                    busy      <= 1'b1;
                    remaining <= len;
                    keep_cs_r <= keep_cs;
                    timer     <= '0;
                    if (len == '0) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else if (!spi_cs_n) begin
                        state <= ISSUE;
                    end else begin
                        state    <= SETUP;
                        spi_cs_n <= 1'b0;
                    end
                end
                SETUP: begin
                    if (timer == SETUP_LAST) state <= ISSUE;
                    else                     timer <= timer + TW'(1);
                end
                ISSUE:   state <= WAIT_HI;
                WAIT_HI: if (spi_busy)  state <= WAIT_LO;
                WAIT_LO: if (!spi_busy) state <= CAPTURE;
                CAPTURE: begin
                    remaining <= remaining - ONE;
                    timer     <= '0;
                    if (issue_next) begin
                        state <= ISSUE;
                    end else if (keep_cs_r) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        state <= HOLD;
                    end
                end
                // CS rises after CS_HOLD low cycles; done follows one cycle later.
                HOLD: begin
                    if (timer == HOLD_LAST) spi_cs_n <= 1'b1;
                    if (timer == HOLD_END) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Scoreboard bench for spi_burst_sequencer with an inline echo SPI controller
// model (response = ~command after an 8-cycle busy window).
module tb_spi_burst_sequencer;
    localparam int DEPTH    = 8;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int LW       = $clog2(DEPTH) + 1;
    localparam int SPI_BITS = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tx_we;
    logic [7:0]    tx_wdata;
    logic          rx_re;
    logic [7:0]    rx_rdata;
    logic          start;
    logic [LW-1:0] len;
    logic          keep_cs;
    logic          busy;
    logic          done;
    logic [LW-1:0] tx_count;
    logic [LW-1:0] rx_count;
    logic          err;
    logic          err_clr;
    logic          spi_trigger;
    logic [7:0]    spi_command;
    logic          spi_busy;
    logic [7:0]    spi_response;
    logic          spi_cs_n;

    spi_burst_sequencer #(.DEPTH(DEPTH), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .tx_we(tx_we), .tx_wdata(tx_wdata),
        .rx_re(rx_re), .rx_rdata(rx_rdata), .start(start), .len(len),
        .keep_cs(keep_cs), .busy(busy), .done(done), .tx_count(tx_count),
        .rx_count(rx_count), .err(err), .err_clr(err_clr),
        .spi_trigger(spi_trigger), .spi_command(spi_command),
        .spi_busy(spi_busy), .spi_response(spi_response), .spi_cs_n(spi_cs_n)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_cmd[$];
    logic [7:0] exp_rx[$];
    int         m_tx = 0;
    int         m_rx = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic push_tx(input logic [7:0] b);
        tx_we = 1'b1;
        tx_wdata = b;
        @(negedge clk);
        tx_we = 1'b0;
        if (m_tx < DEPTH) begin
            exp_cmd.push_back(b);
            m_tx++;
        end
    endtask

    task automatic pop_rx(input string tag);
        logic [7:0] e;
        n_tests++;
        if (exp_rx.size() == 0) begin
            n_fail++;
            $display("FAIL %s rx_pop: got %02h, no byte expected", tag, rx_rdata);
        end else begin
            e = exp_rx.pop_front();
            if (rx_rdata !== e) begin
                n_fail++;
                $display("FAIL %s rx_pop: got %02h expected %02h", tag, rx_rdata, e);
            end
        end
        rx_re = 1'b1;
        @(negedge clk);
        rx_re = 1'b0;
        if (m_rx > 0) m_rx--;
    endtask

    // Starts a burst, plays the SPI controller and checks cycle-level timing.
    task automatic run_burst(input int n, input bit keep, input int first_trig,
                             input int poke_at, input string tag);
        int pops, k, trig_n, first_k, last_t, cs_rise, done_k, done_n;
        int shift_left, unstable, bad_gap, busy_bad, exp_done, exp_rise;
        logic [7:0] cur_cmd, cur_exp;
        logic cs_before, exp_cs_end;
        bit done_seen;
        pops = (n < m_tx) ? n : m_tx;
        for (int i = pops; i < n; i++) exp_cmd.push_back(8'h00);
        m_tx = m_tx - pops;
        cs_before = spi_cs_n;
        trig_n = 0; first_k = -1; last_t = -1; cs_rise = -1; done_k = -1; done_n = 0;
        shift_left = 0; unstable = 0; bad_gap = 0; busy_bad = 0; done_seen = 1'b0;
        cur_cmd = 8'h00; cur_exp = 8'h00;
        start = 1'b1; len = LW'(n); keep_cs = keep;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (k < 600 && !(done_seen && k > done_k + 3)) begin
            if (spi_trigger) begin
                trig_n++;
                if (first_k < 0) first_k = k;
                else if (k - last_t != 10) bad_gap++;
                last_t = k;
                n_tests++;
                if (exp_cmd.size() == 0) begin
                    n_fail++;
                    cur_exp = 8'h00;
                    $display("FAIL %s command: got %02h, no byte expected", tag, spi_command);
                end else begin
                    cur_exp = exp_cmd.pop_front();
                    if (spi_command !== cur_exp) begin
                        n_fail++;
                        $display("FAIL %s command: got %02h expected %02h", tag, spi_command, cur_exp);
                    end
                end
                cur_cmd = spi_command;
                spi_busy = 1'b1;
                shift_left = SPI_BITS;
            end else if (shift_left > 0) begin
                if (spi_command !== cur_cmd) unstable++;
                shift_left--;
                if (shift_left == 0) begin
                    spi_busy = 1'b0;
                    spi_response = ~cur_cmd;
                    if (m_rx < DEPTH) begin
                        exp_rx.push_back(~cur_exp);
                        m_rx++;
                    end
                end
            end
            if (spi_cs_n && cs_rise < 0) cs_rise = k;
            if (done) begin
                done_n++;
                if (!done_seen) begin
                    done_seen = 1'b1;
                    done_k = k;
                end
            end
            if (busy !== (!done_seen || k <= done_k)) busy_bad++;
            start = (k == poke_at);
            if (k == poke_at) len = LW'(7);
            @(negedge clk);
            k++;
        end
        start = 1'b0;

        n_tests++;
        if (!done_seen) begin
            n_fail++;
            $display("FAIL %s done_timeout: no done within %0d cycles", tag, k);
        end
        n_tests++;
        if (done_n != 1) begin
            n_fail++;
            $display("FAIL %s done_pulses: got %0d expected 1", tag, done_n);
        end
        n_tests++;
        if (trig_n != n) begin
            n_fail++;
            $display("FAIL %s triggers: got %0d expected %0d", tag, trig_n, n);
        end
        if (first_trig >= 0) begin
            n_tests++;
            if (first_k != first_trig) begin
                n_fail++;
                $display("FAIL %s first_trigger_cycle: got %0d expected %0d", tag, first_k, first_trig);
            end
        end
        n_tests++;
        if (bad_gap != 0 || unstable != 0) begin
            n_fail++;
            $display("FAIL %s spacing_or_stability: gaps=%0d unstable=%0d expected 0/0", tag, bad_gap, unstable);
        end
        n_tests++;
        if (busy_bad != 0) begin
            n_fail++;
            $display("FAIL %s busy_window: %0d bad cycles expected 0", tag, busy_bad);
        end
        if (n == 0)    exp_done = 1;
        else if (keep) exp_done = last_t + 10;
        else           exp_done = last_t + CS_HOLD + 11;
        n_tests++;
        if (done_k != exp_done) begin
            n_fail++;
            $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_k, exp_done);
        end
        if (n == 0)    exp_rise = cs_before ? 1 : -1;
        else if (keep) exp_rise = -1;
        else           exp_rise = last_t + CS_HOLD + 10;
        n_tests++;
        if (cs_rise != exp_rise) begin
            n_fail++;
            $display("FAIL %s cs_rise_cycle: got %0d expected %0d", tag, cs_rise, exp_rise);
        end
        exp_cs_end = (n == 0) ? cs_before : !keep;
        n_tests++;
        if (spi_cs_n !== exp_cs_end) begin
            n_fail++;
            $display("FAIL %s cs_end: got %0b expected %0b", tag, spi_cs_n, exp_cs_end);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({spi_cs_n, spi_trigger, busy, done, err} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_flags: cs_n/trig/busy/done/err=%05b expected 10000",
                     {spi_cs_n, spi_trigger, busy, done, err});
        end
        n_tests++;
        if (spi_command !== 8'h00 || rx_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: command=%02h rx_rdata=%02h expected 00/00", spi_command, rx_rdata);
        end
        n_tests++;
        if (tx_count !== '0 || rx_count !== '0) begin
            n_fail++;
            $display("FAIL reset_counts: tx=%0d rx=%0d expected 0/0", tx_count, rx_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || spi_cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%0b cs_n=%0b expected 0/1", busy, spi_cs_n);
        end
    endtask

    task automatic test_basic();
        push_tx(8'hA5);
        push_tx(8'h3C);
        n_tests++;
        if (tx_count !== LW'(2)) begin
            n_fail++;
            $display("FAIL basic_tx_count: got %0d expected 2", tx_count);
        end
        run_burst(2, 1'b0, 1 + CS_SETUP, -1, "basic");
        n_tests++;
        if (rx_count !== LW'(2) || tx_count !== '0) begin
            n_fail++;
            $display("FAIL basic_counts: rx=%0d tx=%0d expected 2/0", rx_count, tx_count);
        end
        pop_rx("basic");
        pop_rx("basic");
        rx_re = 1'b1;
        @(negedge clk);
        rx_re = 1'b0;
        n_tests++;
        if (rx_count !== '0 || rx_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL empty_pop: rx_count=%0d rx_rdata=%02h expected 0/00", rx_count, rx_rdata);
        end
    endtask

    task automatic test_dummy();
        run_burst(3, 1'b0, 1 + CS_SETUP, -1, "dummy");
        n_tests++;
        if (rx_count !== LW'(3) || tx_count !== '0) begin
            n_fail++;
            $display("FAIL dummy_counts: rx=%0d tx=%0d expected 3/0", rx_count, tx_count);
        end
        for (int i = 0; i < 3; i++) pop_rx("dummy");
    endtask

    task automatic test_overflow();
        for (int i = 0; i <= DEPTH; i++) push_tx(8'h40 + 8'(i));
        n_tests++;
        if (tx_count !== LW'(DEPTH) || err !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_overflow: tx=%0d err=%0b expected %0d/1", tx_count, err, DEPTH);
        end
        tx_we = 1'b1; tx_wdata = 8'hEE; err_clr = 1'b1;
        @(negedge clk);
        tx_we = 1'b0; err_clr = 1'b0;
        n_tests++;
        if (err !== 1'b1 || tx_count !== LW'(DEPTH)) begin
            n_fail++;
            $display("FAIL clr_vs_overflow: err=%0b tx=%0d expected 1/%0d", err, tx_count, DEPTH);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clr: got %0b expected 0", err);
        end
        run_burst(DEPTH, 1'b0, 1 + CS_SETUP, -1, "full");
        n_tests++;
        if (rx_count !== LW'(DEPTH) || tx_count !== '0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL full_burst: rx=%0d tx=%0d err=%0b expected %0d/0/0", rx_count, tx_count, err, DEPTH);
        end
        run_burst(1, 1'b0, 1 + CS_SETUP, -1, "rx_ovf");
        n_tests++;
        if (rx_count !== LW'(DEPTH) || err !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_overflow: rx=%0d err=%0b expected %0d/1", rx_count, err, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) pop_rx("rx_ovf");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_keep_cs();
        push_tx(8'h11);
        run_burst(1, 1'b1, 1 + CS_SETUP, -1, "keep1");
        repeat (3) @(negedge clk);
        n_tests++;
        if (spi_cs_n !== 1'b0) begin
            n_fail++;
            $display("FAIL keep_cs_idle: cs_n=%0b expected 0", spi_cs_n);
        end
        push_tx(8'h22);
        run_burst(1, 1'b0, 1, -1, "keep2");
        pop_rx("keep");
        pop_rx("keep");
    endtask

    task automatic test_len_zero();
        run_burst(0, 1'b0, -1, -1, "len0");
        n_tests++;
        if (tx_count !== '0 || rx_count !== '0) begin
            n_fail++;
            $display("FAIL len0_counts: tx=%0d rx=%0d expected 0/0", tx_count, rx_count);
        end
    endtask

    task automatic test_start_while_busy();
        push_tx(8'h91);
        push_tx(8'h92);
        push_tx(8'h93);
        run_burst(3, 1'b0, 1 + CS_SETUP, 12, "busy_start");
        for (int i = 0; i < 3; i++) pop_rx("busy_start");
        n_tests++;
        if (rx_count !== '0 || exp_cmd.size() != 0) begin
            n_fail++;
            $display("FAIL busy_start_left: rx=%0d pending_cmds=%0d expected 0/0", rx_count, exp_cmd.size());
        end
    endtask

    task automatic test_reset_mid();
        int k;
        push_tx(8'h81);
        push_tx(8'h82);
        start = 1'b1; len = LW'(2); keep_cs = 1'b0;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!spi_trigger && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (!spi_trigger) begin
            n_fail++;
            $display("FAIL rst_mid_trigger: no trigger within 50 cycles");
        end
        spi_busy = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (spi_cs_n !== 1'b1 || busy !== 1'b0 || spi_trigger !== 1'b0 || spi_command !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: cs_n=%0b busy=%0b trig=%0b cmd=%02h expected 1/0/0/00",
                     spi_cs_n, busy, spi_trigger, spi_command);
        end
        n_tests++;
        if (tx_count !== '0 || rx_count !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_fifos: tx=%0d rx=%0d expected 0/0", tx_count, rx_count);
        end
        spi_busy = 1'b0;
        exp_cmd.delete();
        exp_rx.delete();
        m_tx = 0;
        m_rx = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_tx(8'h5F);
        run_burst(1, 1'b0, 1 + CS_SETUP, -1, "post_rst");
        pop_rx("post_rst");
    endtask

    initial begin
        rst_n = 1'b0;
        tx_we = 1'b0; tx_wdata = 8'h00; rx_re = 1'b0;
        start = 1'b0; len = '0; keep_cs = 1'b0; err_clr = 1'b0;
        spi_busy = 1'b0; spi_response = 8'h00;
        test_reset();
        test_basic();
        test_dummy();
        test_overflow();
        test_keep_cs();
        test_len_zero();
        test_start_while_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_burst_sequencer.md
# spi_burst_sequencer

Sequences multi-byte SPI transactions on top of the existing byte-wide SPI controller so the core no longer has to trigger, poll and read one byte at a time. It buffers outgoing bytes in a TX FIFO, issues them back-to-back to the SPI controller under a single chip-select window, and collects response bytes in an RX FIFO. It sits between the load/store unit's memory-mapped register space and the SPI controller, and owns the chip-select output.

## Interface
Parameters:
- DEPTH, 8, entries per FIFO; power of two, ≥2
- CS_SETUP, 4, cycles chip-select is low before the first trigger (≥1)
- CS_HOLD, 4, cycles chip-select stays low after the last capture (≥1)

Ports (LW = $clog2(DEPTH)+1):
- clk  input  1  core clock
- rst_n  input  1  reset, asynchronous, active-low
- tx_we  input  1  push tx_wdata into TX FIFO
- tx_wdata  input  8  byte to transmit
- rx_re  input  1  pop RX FIFO head
- rx_rdata  output  8  RX FIFO head (first-word-fall-through); 0x00 when empty
- start  input  1  begin burst; ignored while busy
- len  input  LW  bytes in burst, sampled on accepted start
- keep_cs  input  1  sampled on accepted start; 1 = leave CS low after burst
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse at burst end
- tx_count, rx_count  output  LW  FIFO occupancies
- err  output  1  sticky overflow flag
- err_clr  input  1  clears err
- spi_trigger  output  1  one-cycle start pulse to SPI controller
- spi_command  output  8  byte to shift; held stable from trigger until spi_busy falls
- spi_busy  input  1  SPI controller shifting
- spi_response  input  8  received byte, valid when spi_busy low
- spi_cs_n  output  1  chip-select, active-low

## Operation
- States: IDLE, SETUP, ISSUE, WAIT_HI, WAIT_LO, CAPTURE, HOLD, FINISH.
- IDLE: start && !busy → latch len into remaining counter, latch keep_cs. len==0 → FINISH (no CS activity). Else if spi_cs_n already low (prior keep_cs) → ISSUE, otherwise → SETUP with spi_cs_n=0.
- SETUP: count CS_SETUP cycles → ISSUE.
- ISSUE: spi_trigger=1 for exactly one cycle; spi_command = TX head and TX popped, or 0x00 dummy if TX empty (no pop). → WAIT_HI.
- WAIT_HI: wait spi_busy=1 → WAIT_LO.
- WAIT_LO: wait spi_busy=0 → CAPTURE.
- CAPTURE: push spi_response into RX; if RX full, byte dropped, err set. Decrement remaining; remaining>0 → ISSUE; else keep_cs → FINISH, else → HOLD.
- HOLD: count CS_HOLD cycles, then spi_cs_n=1 → FINISH.
- FINISH: done=1, busy=0 next cycle → IDLE.
- TX push when full: dropped, err set. RX pop when empty: no effect.
- Simultaneous push/pop on either FIFO, including when full: both performed, count unchanged.
- err_clr and a new overflow in the same cycle: err stays 1.
- FIFO pointers wrap modulo DEPTH; counts saturate at DEPTH by construction.

## Timing
- Reset values: spi_cs_n=1; spi_trigger, busy, done, err = 0; spi_command=0x00; both FIFOs empty, counts 0; rx_rdata=0x00; state IDLE.
- Reset asserted mid-burst: immediate return to reset values, including releasing CS; in-flight SPI byte is abandoned.
- Start accepted at cycle 0 → busy=1 and spi_cs_n=0 at cycle 1 → spi_trigger at cycle 1+CS_SETUP.
- Capture-to-next-trigger: 1 cycle (CAPTURE, then ISSUE).
- Last capture → spi_cs_n=1 after CS_HOLD cycles → done pulse the following cycle.
- len==0: done pulse at cycle 1, spi_cs_n never toggles.
- rx_rdata and counts update the cycle after push/pop.

## Test plan
- Push 0xA5,0x3C; start len=2, keep_cs=0; SPI model echoes ~cmd after 8 busy cycles → two triggers with commands 0xA5, 0x3C under one CS window; RX holds 0x5A,0xC3; done once; spi_cs_n high.
- Empty TX, start len=3 → three triggers with command 0x00; rx_count=3; tx_count stays 0.
- Push DEPTH+1 bytes → tx_count=DEPTH, err=1; err_clr → err=0.
- Two bursts, first keep_cs=1 → spi_cs_n stays low between bursts; second burst issues its first trigger 1 cycle after start (no SETUP).
- start len=0 → done at cycle 1, no trigger, no CS change; start while busy → ignored, remaining count unchanged.
- Assert rst_n low during WAIT_LO → spi_cs_n=1, busy=0, FIFOs empty immediately; post-reset burst completes normally.
